// File: rtl/st7066u_write_engine.sv
// st7066u_write_engine
//   Write engine for an ST7066U character LCD. Accepts one instruction/data
//   byte per valid/ready handshake and sequences RS/RW/E/DB with programmable
//   setup, enable-high, enable-low and execution-wait timing, in 8-bit or
//   4-bit bus mode. A power-on delay is enforced after every reset.
//
//   Optional feature macro: LCD_LONG_EXEC_EN
//     defined   - clear (8'h01) and return-home (8'h02/8'h03) instructions
//                 wait CLEAR_CYCLES; everything else waits EXEC_CYCLES.
//     undefined - every write waits EXEC_CYCLES.
//
// Ports
//   i_clk, i_reset   clock; synchronous active-high reset
//   i_valid/o_ready  request handshake (o_busy = ~o_ready)
//   i_rs, i_data     0 = instruction / 1 = data, byte to write
//   o_lcd_rs/rw/e    LCD control pins (rw is tied 0)
//   o_lcd_db         LCD DB7..DB0; in 4-bit mode nibble on [7:4], [3:0] = 0
module st7066u_write_engine #(
  parameter int unsigned BUS_WIDTH      = 8,
  parameter int unsigned SETUP_CYCLES   = 1,
  parameter int unsigned E_HIGH_CYCLES  = 3,
  parameter int unsigned E_LOW_CYCLES   = 11,
  parameter int unsigned EXEC_CYCLES    = 444,
  parameter int unsigned CLEAR_CYCLES   = 18240,
  parameter int unsigned POWERUP_CYCLES = 480000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_db
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAXP = max2(max2(max2(SETUP_CYCLES, E_HIGH_CYCLES),
                                           max2(E_LOW_CYCLES, EXEC_CYCLES)),
                                      max2(CLEAR_CYCLES, POWERUP_CYCLES));
  localparam int unsigned CW = $clog2(MAXP) + 1;
  localparam bit FOUR_BIT = (BUS_WIDTH == 4);

  localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_HIGH    = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LD_LOW     = CW'(E_LOW_CYCLES - 1);
  localparam logic [CW-1:0] LD_EXEC    = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] LD_POWERUP = CW'(POWERUP_CYCLES - 1);

  // The NEXT_NIBBLE step takes no cycle of its own: it is folded into the
  // HOLD -> SETUP transition, where DB is reloaded with the low nibble.
  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rs_q, rs_n;
  logic [7:0]    db_q, db_n;
  logic [3:0]    lo_q, lo_n;
  logic          second_q, second_n;
  logic          ready_q, e_q;
  logic [CW-1:0] exec_load;

`ifdef LCD_LONG_EXEC_EN
  localparam logic [CW-1:0] LD_CLEAR = CW'(CLEAR_CYCLES - 1);
  logic long_q, long_n;
  logic is_long;

  assign is_long   = !i_rs && ((i_data == 8'h01) || (i_data[7:1] == 7'b0000001));
  assign exec_load = long_q ? LD_CLEAR : LD_EXEC;
`else
  assign exec_load = LD_EXEC;
`endif

  always_comb begin
    state_n  = state;
    cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
    rs_n     = rs_q;
    db_n     = db_q;
    lo_n     = lo_q;
    second_n = second_q;
`ifdef LCD_LONG_EXEC_EN
    long_n   = long_q;
`endif
    unique case (state)
      S_POWERUP: begin
        if (cnt == '0) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (i_valid) begin
          rs_n     = i_rs;
          db_n     = FOUR_BIT ? {i_data[7:4], 4'h0} : i_data;
          lo_n     = i_data[3:0];
          second_n = 1'b0;
`ifdef LCD_LONG_EXEC_EN
          long_n   = is_long;
`endif
          cnt_n    = LD_SETUP;
          state_n  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          cnt_n   = LD_HIGH;
          state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt == '0) begin
          cnt_n   = LD_LOW;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          if (FOUR_BIT && !second_q) begin
            db_n     = {lo_q, 4'h0};
            second_n = 1'b1;
            cnt_n    = LD_SETUP;
            state_n  = S_SETUP;
          end else begin
            cnt_n   = exec_load;
            state_n = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (cnt == '0) state_n = S_IDLE;
      end
      default: begin
        cnt_n   = LD_POWERUP;
        state_n = S_POWERUP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_POWERUP;
      cnt      <= LD_POWERUP;
      rs_q     <= 1'b0;
      db_q     <= '0;
      lo_q     <= '0;
      second_q <= 1'b0;
      ready_q  <= 1'b0;
      e_q      <= 1'b0;
`ifdef LCD_LONG_EXEC_EN
      long_q   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rs_q     <= rs_n;
      db_q     <= db_n;
      lo_q     <= lo_n;
      second_q <= second_n;
      // Pins registered from next state so E and ready are glitch-free.
      ready_q  <= (state_n == S_IDLE);
      e_q      <= (state_n == S_PULSE);
`ifdef LCD_LONG_EXEC_EN
      long_q   <= long_n;
`endif
    end
  end

  assign o_ready  = ready_q;
  assign o_busy   = ~ready_q;
  assign o_lcd_rs = rs_q;
  assign o_lcd_rw = 1'b0;
  assign o_lcd_e  = e_q;
  assign o_lcd_db = db_q;

endmodule

// File: tb/tb_st7066u_write_engine.sv
// tb_st7066u_write_engine
//   Drives an 8-bit and a 4-bit instance of st7066u_write_engine and compares
//   every pin, cycle by cycle, against timing computed from S/H/L/W arithmetic.
module tb_st7066u_write_engine;

  localparam int S = 1, H = 2, L = 3, EXEC = 5, CLEAR = 20, PWR = 10;
  localparam int WIN = S + H + L;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       v8 = 1'b0, rs8 = 1'b0, rdy8, busy8, lrs8, lrw8, le8;
  logic [7:0] d8 = '0, db8;
  logic       v4 = 1'b0, rs4 = 1'b0, rdy4, busy4, lrs4, lrw4, le4;
  logic [7:0] d4 = '0, db4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  st7066u_write_engine #(
    .BUS_WIDTH(8), .SETUP_CYCLES(S), .E_HIGH_CYCLES(H), .E_LOW_CYCLES(L),
    .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR), .POWERUP_CYCLES(PWR)
  ) dut8 (
    .i_clk(clk), .i_reset(reset), .i_valid(v8), .o_ready(rdy8), .i_rs(rs8),
    .i_data(d8), .o_busy(busy8), .o_lcd_rs(lrs8), .o_lcd_rw(lrw8),
    .o_lcd_e(le8), .o_lcd_db(db8)
  );

  st7066u_write_engine #(
    .BUS_WIDTH(4), .SETUP_CYCLES(S), .E_HIGH_CYCLES(H), .E_LOW_CYCLES(L),
    .EXEC_CYCLES(EXEC), .CLEAR_CYCLES(CLEAR), .POWERUP_CYCLES(PWR)
  ) dut4 (
    .i_clk(clk), .i_reset(reset), .i_valid(v4), .o_ready(rdy4), .i_rs(rs4),
    .i_data(d4), .o_busy(busy4), .o_lcd_rs(lrs4), .o_lcd_rw(lrw4),
    .o_lcd_e(le4), .o_lcd_db(db4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_wait(input bit rs, input logic [7:0] d);
`ifdef LCD_LONG_EXEC_EN
    if (!rs && (d == 8'h01 || (d >> 1) == 8'h01)) return CLEAR;
`endif
    return EXEC;
  endfunction

  task automatic drive(input int bw, input bit v, input bit rs, input logic [7:0] d);
    if (bw == 8) begin v8 = v; rs8 = rs; d8 = d; end
    else         begin v4 = v; rs4 = rs; d4 = d; end
  endtask

  task automatic sample(input int bw, output bit rdy, output bit busy, output bit e,
                        output bit rs, output bit rw, output logic [7:0] db);
    if (bw == 8) begin rdy = rdy8; busy = busy8; e = le8; rs = lrs8; rw = lrw8; db = db8; end
    else         begin rdy = rdy4; busy = busy4; e = le4; rs = lrs4; rw = lrw4; db = db4; end
  endtask

  // Waits (bounded) for ready, presents the request and steps past the accept edge.
  task automatic accept(input int bw, input bit rs, input logic [7:0] d, output bit ok);
    bit rdy, busy, e, lrs, rw;
    logic [7:0] db;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      sample(bw, rdy, busy, e, lrs, rw, db);
      if (rdy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check("ready_timeout", 32'd0, 32'd1);
      return;
    end
    drive(bw, 1'b1, rs, d);
    @(posedge clk); #1;
  endtask

  // One full write; t counts edges after the accept edge.
  task automatic run_txn(input int bw, input bit rs, input logic [7:0] d, input bit hold);
    bit ok, rdy, busy, e, lrs, rw, e_exp;
    logic [7:0] db, db_exp;
    int total;
    accept(bw, rs, d, ok);
    if (!ok) return;
    total = ((bw == 4) ? 2 : 1) * WIN + exp_wait(rs, d);
    if (!hold) drive(bw, 1'b0, 1'b0, 8'h00);
    for (int t = 0; t <= total; t++) begin
      sample(bw, rdy, busy, e, lrs, rw, db);
      e_exp = (t >= S && t < S + H) ||
              (bw == 4 && t >= WIN + S && t < WIN + S + H);
      if (bw == 8)      db_exp = d;
      else if (t < WIN) db_exp = {d[7:4], 4'h0};
      else              db_exp = {d[3:0], 4'h0};
      check("ready", 32'(rdy),  32'(t >= total));
      check("busy",  32'(busy), 32'(t < total));
      check("e",     32'(e),    32'(e_exp));
      check("rs",    32'(lrs),  32'(rs));
      check("rw",    32'(rw),   32'd0);
      check("db",    32'(db),   32'(db_exp));
      if (t < total) begin
        if (hold) drive(bw, 1'b1, 1'($urandom), 8'($urandom));
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic powerup_check();
    @(negedge clk);
    reset = 1'b0;
    for (int j = 1; j <= PWR; j++) begin
      @(posedge clk); #1;
      check("pwr_ready8", 32'(rdy8), 32'(j == PWR));
      check("pwr_ready4", 32'(rdy4), 32'(j == PWR));
      check("pwr_e",      32'({le8, le4}), 32'd0);
      check("pwr_rw",     32'({lrw8, lrw4}), 32'd0);
      check("pwr_db",     32'({db8, db4}), 32'd0);
    end
  endtask

  initial begin
    bit ok;
    logic [7:0] d;
    bit rs;
    int bw;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(rdy8), 32'd0);
    check("rst_busy",  32'(busy8), 32'd1);
    check("rst_e",     32'(le8), 32'd0);
    check("rst_rs",    32'(lrs8), 32'd0);
    check("rst_db",    32'(db8), 32'd0);
    powerup_check();

    run_txn(8, 1'b1, 8'h41, 1'b0);
    run_txn(4, 1'b0, 8'h28, 1'b0);
    run_txn(8, 1'b0, 8'h01, 1'b0);
    run_txn(8, 1'b0, 8'h03, 1'b0);
    run_txn(8, 1'b1, 8'h01, 1'b0);
    run_txn(4, 1'b0, 8'h02, 1'b0);

    // valid held high across back-to-back writes, data churning while busy
    run_txn(8, 1'b1, 8'h5A, 1'b1);
    run_txn(8, 1'b0, 8'hC3, 1'b1);
    run_txn(4, 1'b1, 8'h9E, 1'b1);
    run_txn(4, 1'b0, 8'h01, 1'b1);
    drive(8, 1'b0, 1'b0, 8'h00);
    drive(4, 1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 30; i++) begin
      bw = ($urandom_range(0, 1) == 0) ? 8 : 4;
      rs = 1'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      run_txn(bw, rs, d, 1'($urandom));
      drive(bw, 1'b0, 1'b0, 8'h00);
    end

    // reset in the middle of the enable pulse
    accept(8, 1'b1, 8'hA5, ok);
    drive(8, 1'b0, 1'b0, 8'h00);
    if (ok) begin
      repeat (S) begin @(posedge clk); #1; end
      check("pulse_e", 32'(le8), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_e",     32'(le8), 32'd0);
      check("rst_mid_ready", 32'(rdy8), 32'd0);
      powerup_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
